// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch front end.
// Imported by the fetch top level and its prefetch FIFO.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetchState_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {instr, pc} pairs.
// Head entry is read straight from registered storage.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Push,
    input  logic [WIDTH-1:0]         PushData,
    input  logic                     Pop,
    input  logic                     Flush,
    output logic [WIDTH-1:0]         HeadData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign Full   = (count == FULL_COUNT);
    assign Empty  = (count == '0);
    assign doPop  = Pop && !Empty;
    assign doPush = Push && !Flush && (!Full || doPop);

    // Storage, pointers and occupancy; flush only rewinds the pointers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (Flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= PushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

    assign HeadData = mem[rdPtr];
    assign Count    = count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues one-at-a-time word reads,
// buffers returned words for decode and drops wrong-path data on redirect.
module fetch_prefetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst,
    output logic               ImemReq,
    output logic [31:0]        ImemRdAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemRdData,
    output logic               InstrValid,
    input  logic               DecodeReady,
    output logic [INSTR_W-1:0] Instruction,
    output logic [31:0]        PCOut,
    output logic [31:0]        PCPlus4,
    input  logic               Redirect,
    input  logic [31:0]        RedirectPC
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    fetchState_t state;

    logic [31:0]          FetchPC;
    logic [31:0]          reqAddr;
    logic                 outstanding;
    logic [CW-1:0]        count;
    logic [CW:0]          inFlight;
    logic                 full;
    logic                 empty;
    logic [INSTR_W+31:0]  headData;
    logic                 ackValid;
    logic                 push;
    logic                 pop;

    assign inFlight = {1'b0, count} + {{CW{1'b0}}, outstanding};

    assign ImemReq    = !Rst && (outstanding || (inFlight < DEPTH_C));
    assign ImemRdAddr = outstanding ? reqAddr : FetchPC;

    assign ackValid = ImemAck && ImemReq;
    assign push     = ackValid && (state == FETCH) && !Redirect
                      && (!full || pop);
    assign pop      = InstrValid && DecodeReady;

    assign InstrValid  = !empty;
    assign Instruction = headData[INSTR_W+31:32];
    assign PCOut       = headData[31:0];
    assign PCPlus4     = PCOut + 32'd4;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + 32)
    ) uFifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .Push     (push),
        .PushData ({ImemRdData, FetchPC}),
        .Pop      (pop),
        .Flush    (Redirect),
        .HeadData (headData),
        .Count    (count),
        .Full     (full),
        .Empty    (empty)
    );

    // Fetch PC, held request address and the wrong-path discard FSM.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= FETCH;
            FetchPC     <= RESET_PC & WORD_MASK;
            reqAddr     <= RESET_PC & WORD_MASK;
            outstanding <= 1'b0;
        end else begin
            if (ackValid) begin
                outstanding <= 1'b0;
            end else if (ImemReq) begin
                outstanding <= 1'b1;
                reqAddr     <= ImemRdAddr;
            end

            if (Redirect) begin
                FetchPC <= RedirectPC & WORD_MASK;
            end else if (push) begin
                FetchPC <= FetchPC + 32'd4;
            end

            unique case (state)
                FETCH: begin
                    if (Redirect && ImemReq && !ImemAck) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (ackValid) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: vector table, hand-written redirect and
// wrap sequences, then randomized traffic against a queue-based model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Rst;
    logic        ImemReq;
    logic [31:0] ImemRdAddr;
    logic        ImemAck;
    logic [31:0] ImemRdData;
    logic        InstrValid;
    logic        DecodeReady;
    logic [31:0] Instruction;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4;
    logic        Redirect;
    logic [31:0] RedirectPC;

    int checks;
    int failures;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ImemReq     (ImemReq),
        .ImemRdAddr  (ImemRdAddr),
        .ImemAck     (ImemAck),
        .ImemRdData  (ImemRdData),
        .InstrValid  (InstrValid),
        .DecodeReady (DecodeReady),
        .Instruction (Instruction),
        .PCOut       (PCOut),
        .PCPlus4     (PCPlus4),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    function automatic vec_t mk(
        input logic ack, input logic rdy,
        input logic eReq, input logic [31:0] eAddr,
        input logic eValid, input logic [31:0] ePc
    );
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.rdr = 1'b0; v.rpc = '0;
        v.eReq = eReq; v.eAddr = eAddr;
        v.eValid = eValid; v.ePc = ePc;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, " req"},   32'(ImemReq), 32'd0);
        chk({tag, " addr"},  ImemRdAddr, 32'h0);
        chk({tag, " valid"}, 32'(InstrValid), 32'd0);
        chk({tag, " instr"}, Instruction, 32'h0);
        chk({tag, " pc"},    PCOut, 32'h0);
        chk({tag, " pc4"},   PCPlus4, 32'h4);
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance.
    task automatic step(input string tag, input vec_t v);
        chk({tag, " req"},   32'(ImemReq), 32'(v.eReq));
        chk({tag, " addr"},  ImemRdAddr, v.eAddr);
        chk({tag, " valid"}, 32'(InstrValid), 32'(v.eValid));
        if (v.eValid) begin
            chk({tag, " instr"}, Instruction, instrFor(v.ePc));
            chk({tag, " pc"},    PCOut, v.ePc);
            chk({tag, " pc4"},   PCPlus4, v.ePc + 32'd4);
        end
        ImemAck     = v.ack;
        ImemRdData  = instrFor(v.eAddr);
        DecodeReady = v.rdy;
        Redirect    = v.rdr;
        RedirectPC  = v.rpc;
        @(negedge Clk);
        #1;
    endtask

    task automatic rdr(inout vec_t v, input logic [31:0] pc);
        v.rdr = 1'b1;
        v.rpc = pc;
    endtask

    task automatic idleInputs();
        ImemAck     = 1'b0;
        ImemRdData  = '0;
        DecodeReady = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = '0;
    endtask

    task automatic releaseReset();
        @(negedge Clk);
        #1;
        Rst = 1'b0;
        #1;
    endtask

    vec_t tbl[13];
    vec_t v;

    ent_t        q[$];
    logic [31:0] mFetch;
    logic        mOut;
    logic [31:0] mOutAddr;
    logic        mDrop;
    logic        memBusy;
    int          memWait;

    initial begin
        checks   = 0;
        failures = 0;
        Rst      = 1'b1;
        idleInputs();

        // zero-wait stream, then DecodeReady low until full, then latency
        tbl[0]  = mk(1, 1, 1, 32'd0,  0, 32'd0);
        tbl[1]  = mk(1, 1, 1, 32'd4,  1, 32'd0);
        tbl[2]  = mk(1, 1, 1, 32'd8,  1, 32'd4);
        tbl[3]  = mk(1, 0, 1, 32'd12, 1, 32'd8);
        tbl[4]  = mk(1, 0, 1, 32'd16, 1, 32'd8);
        tbl[5]  = mk(1, 0, 1, 32'd20, 1, 32'd8);
        tbl[6]  = mk(0, 0, 0, 32'd24, 1, 32'd8);
        tbl[7]  = mk(0, 1, 0, 32'd24, 1, 32'd8);
        tbl[8]  = mk(1, 1, 1, 32'd24, 1, 32'd12);
        tbl[9]  = mk(0, 1, 1, 32'd28, 1, 32'd16);
        tbl[10] = mk(0, 0, 1, 32'd28, 1, 32'd20);
        tbl[11] = mk(1, 0, 1, 32'd28, 1, 32'd20);
        tbl[12] = mk(0, 1, 1, 32'd32, 1, 32'd20);

        @(negedge Clk);
        #1;
        checkReset("reset");
        Rst = 1'b0;
        #1;
        for (int i = 0; i < 13; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // asynchronous reset mid-stream with a request outstanding
        Rst = 1'b1;
        #1;
        checkReset("midrst");
        idleInputs();
        releaseReset();

        // fill, then redirect while the 0x10 request is outstanding
        step("b0", mk(1, 0, 1, 32'h00, 0, 32'h00));
        step("b1", mk(1, 0, 1, 32'h04, 1, 32'h00));
        step("b2", mk(1, 0, 1, 32'h08, 1, 32'h00));
        step("b3", mk(1, 0, 1, 32'h0C, 1, 32'h00));
        step("b4", mk(0, 1, 0, 32'h10, 1, 32'h00));
        step("b5", mk(0, 0, 1, 32'h10, 1, 32'h04));
        v = mk(0, 0, 1, 32'h10, 1, 32'h04);
        rdr(v, 32'h0000_0043);
        step("b6", v);
        step("b7", mk(1, 0, 1, 32'h10, 0, 32'h00));
        step("b8", mk(1, 0, 1, 32'h40, 0, 32'h00));
        step("b9", mk(0, 1, 1, 32'h44, 1, 32'h40));
        step("b10", mk(1, 1, 1, 32'h44, 0, 32'h00));
        // redirect together with an ack and a pop
        v = mk(1, 1, 1, 32'h48, 1, 32'h44);
        rdr(v, 32'h0000_0080);
        step("c11", v);
        step("c12", mk(1, 1, 1, 32'h80, 0, 32'h00));
        // redirect near the top of the address space
        v = mk(0, 1, 1, 32'h84, 1, 32'h80);
        rdr(v, 32'hFFFF_FFF8);
        step("c13", v);
        step("c14", mk(1, 1, 1, 32'h84, 0, 32'h00));
        step("c15", mk(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
        step("c16", mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8));
        step("c17", mk(0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC));
        step("c18", mk(0, 0, 1, 32'h0, 0, 32'h0));

        // randomized traffic against the reference model
        Rst = 1'b1;
        idleInputs();
        #1;
        q.delete();
        mFetch   = 32'h0;
        mOut     = 1'b0;
        mOutAddr = 32'h0;
        mDrop    = 1'b0;
        memBusy  = 1'b0;
        memWait  = 0;
        releaseReset();

        for (int n = 0; n < 4000; n++) begin
            logic        eReq;
            logic [31:0] eAddr;
            logic        eValid;
            logic        a;
            logic        ack;
            logic        rdy;
            logic        rd;
            logic [31:0] rpc;
            logic [31:0] data;

            eReq   = mOut || (q.size() < DEPTH);
            eAddr  = mOut ? mOutAddr : mFetch;
            eValid = (q.size() > 0);
            chk("rnd req",   32'(ImemReq), 32'(eReq));
            chk("rnd addr",  ImemRdAddr, eAddr);
            chk("rnd valid", 32'(InstrValid), 32'(eValid));
            if (eValid) begin
                chk("rnd instr", Instruction, q[0].instr);
                chk("rnd pc",    PCOut, q[0].pc);
                chk("rnd pc4",   PCPlus4, q[0].pc + 32'd4);
            end

            ack = 1'b0;
            if (!memBusy && ImemReq) begin
                memBusy = 1'b1;
                memWait = $urandom_range(0, 3);
            end
            if (memBusy) begin
                if (memWait == 0) begin
                    ack     = 1'b1;
                    memBusy = 1'b0;
                end else begin
                    memWait--;
                end
            end
            data = $urandom;
            rdy  = ($urandom_range(0, 9) < 7);
            rd   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end else begin
                rpc = $urandom;
            end

            ImemAck     = ack;
            ImemRdData  = data;
            DecodeReady = rdy;
            Redirect    = rd;
            RedirectPC  = rpc;

            a = ack && eReq;
            if (eValid && rdy) begin
                void'(q.pop_front());
            end
            if (rd) begin
                q.delete();
                mFetch = rpc & 32'hFFFF_FFFC;
                if (eReq && !a) begin
                    mOutAddr = eAddr;
                    mOut     = 1'b1;
                    mDrop    = 1'b1;
                end else begin
                    mOut  = 1'b0;
                    mDrop = 1'b0;
                end
            end else if (a) begin
                if (!mDrop) begin
                    q.push_back('{instr: data, pc: mFetch});
                    mFetch = mFetch + 32'd4;
                end
                mDrop = 1'b0;
                mOut  = 1'b0;
            end else if (eReq) begin
                mOutAddr = eAddr;
                mOut     = 1'b1;
            end

            @(negedge Clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
